neopix_frame_sched: RTL and testbench

Frame scheduler for the SPI-to-NeoPixel path. It owns the double-buffered LED RAM bank assignment and decides when a committed SPI frame is swapped in. It also issues ws2812 start pulses, enforces the WS2812 latch gap between transmissions, and optionally re-sends the displayed frame at a fixed refresh rate. It sits between the SPI frame-capture logic and the ws2812 serializer, replacing their ad-hoc bank toggling.

---
 rtl/neopix_frame_sched_pkg.sv | 24 ++
 rtl/neopix_interval_timer.sv | 28 ++
 rtl/neopix_frame_sched.sv | 160 ++++++++++++++++
 tb/tb_neopix_frame_sched.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neopix_frame_sched_pkg.sv
// Shared definitions for the NeoPixel frame scheduler: FSM state encodings
// and the count-width / latch-gap derivations used by the SPI and ws2812 paths.
package neopix_frame_sched_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;

  // Last WAIT_BUSY cycle index before a start is treated as lost (8 cycles).
  localparam logic [2:0] WAIT_BUSY_LAST = 3'd7;

  function automatic int count_width(input int num_leds);
    return $clog2(num_leds) + 1;
  endfunction

  function automatic int latch_cycles(input int clk_hz, input int latch_us);
    int c;
    c = (clk_hz / 1000000) * latch_us;
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/neopix_interval_timer.sv
// Loadable down-counter that saturates at zero and flags when it is there.
module neopix_interval_timer #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count;

  // Load has priority; otherwise count down and hold at zero.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count <= RESET_VALUE;
    end else if (load_i) begin
      count <= value_i;
    end else if (count != {WIDTH{1'b0}}) begin
      count <= count - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign zero_o = (count == {WIDTH{1'b0}});

endmodule

// File: rtl/neopix_frame_sched.sv
// Frame scheduler: owns the LED RAM double-buffer bank assignment, swaps in
// committed SPI frames, issues ws2812 start pulses and enforces the latch gap.
module neopix_frame_sched
  import neopix_frame_sched_pkg::*;
#(
  parameter  int NUM_LEDS     = 8,
  parameter  int SYSTEM_CLOCK = 50000000,
  parameter  int LATCH_US     = 300,
  parameter  int REFRESH_HZ   = 1000,
  localparam int CW           = count_width(NUM_LEDS)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          spi_begin_i,
  input  logic          spi_end_i,
  input  logic [CW-1:0] spi_count_i,
  input  logic          refresh_en_i,
  input  logic          ws_busy_i,
  output logic          ws_start_o,
  output logic          wr_bank_o,
  output logic          rd_bank_o,
  output logic [CW-1:0] ws_count_o,
  output logic          pending_o,
  output logic          drop_o,
  output logic [15:0]   frames_o
);

  localparam int TW             = 32;
  localparam int LATCH_CYCLES   = latch_cycles(SYSTEM_CLOCK, LATCH_US);
  localparam int REFRESH_CYCLES = SYSTEM_CLOCK / REFRESH_HZ;

  localparam logic [TW-1:0] GAP_LOAD     = TW'(LATCH_CYCLES - 1);
  localparam logic [TW-1:0] REFRESH_LOAD = TW'(REFRESH_CYCLES);
  localparam logic [CW-1:0] MAX_COUNT    = CW'(NUM_LEDS);

  logic [2:0]    state;
  logic [2:0]    next_state;
  logic [2:0]    wait_cnt;
  logic [CW-1:0] commit_count;
  logic [CW-1:0] clamped_count;
  logic          swap;
  logic          overrun;
  logic          gap_load;
  logic          gap_zero;
  logic          refresh_load;
  logic          refresh_zero;

  assign swap         = (state == ST_IDLE) && pending_o;
  // A swap in the same cycle as spi_begin wins; a simultaneous spi_end masks the begin.
  assign overrun      = spi_begin_i && !spi_end_i && pending_o && !swap;
  assign gap_load     = (state == ST_SEND) && !ws_busy_i;
  assign refresh_load = (state == ST_START);

  // Clamp the SPI-reported count to the bank size.
  always_comb begin
    clamped_count = spi_count_i;
    if (spi_count_i > MAX_COUNT) begin
      clamped_count = MAX_COUNT;
    end else begin
      clamped_count = spi_count_i;
    end
  end

  // Scheduler next-state decision.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (pending_o) begin
          next_state = ST_START;
        end else if (refresh_en_i && refresh_zero) begin
          next_state = ST_START;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_START: next_state = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (ws_busy_i) begin
          next_state = ST_SEND;
        end else if (wait_cnt == WAIT_BUSY_LAST) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_WAIT_BUSY;
        end
      end
      ST_SEND: begin
        if (!ws_busy_i) begin
          next_state = ST_GAP;
        end else begin
          next_state = ST_SEND;
        end
      end
      ST_GAP: begin
        if (gap_zero) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_GAP;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State, bank assignment, commit register and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= ST_IDLE;
      wait_cnt     <= 3'd0;
      wr_bank_o    <= 1'b0;
      rd_bank_o    <= 1'b1;
      ws_count_o   <= {CW{1'b0}};
      commit_count <= {CW{1'b0}};
      pending_o    <= 1'b0;
      ws_start_o   <= 1'b0;
      drop_o       <= 1'b0;
      frames_o     <= 16'd0;
    end else begin
      state      <= next_state;
      ws_start_o <= (next_state == ST_START);
      wait_cnt   <= (state == ST_WAIT_BUSY) ? (wait_cnt + 3'd1) : 3'd0;
      drop_o     <= overrun;
      if (swap) begin
        wr_bank_o  <= ~wr_bank_o;
        rd_bank_o  <= wr_bank_o;
        ws_count_o <= commit_count;
        frames_o   <= frames_o + 16'd1;
      end
      if (spi_end_i) begin
        pending_o    <= 1'b1;
        commit_count <= clamped_count;
      end else if (swap || overrun) begin
        pending_o <= 1'b0;
      end
    end
  end

  neopix_interval_timer #(
    .WIDTH       (TW),
    .RESET_VALUE ({TW{1'b0}})
  ) gap_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (gap_load),
    .value_i (GAP_LOAD),
    .zero_o  (gap_zero)
  );

  neopix_interval_timer #(
    .WIDTH       (TW),
    .RESET_VALUE (REFRESH_LOAD)
  ) refresh_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (refresh_load),
    .value_i (REFRESH_LOAD),
    .zero_o  (refresh_zero)
  );

endmodule

// File: tb/tb_neopix_frame_sched.sv
// Self-checking bench for neopix_frame_sched with a scaled clock so latch gap
// (20 cycles) and refresh period (200 cycles) stay short.
module tb_neopix_frame_sched;

  localparam int NUM_LEDS       = 8;
  localparam int SYSTEM_CLOCK   = 1000000;
  localparam int LATCH_US       = 20;
  localparam int REFRESH_HZ     = 5000;
  localparam int LATCH_CYCLES   = 20;
  localparam int REFRESH_CYCLES = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_begin = 1'b0;
  logic        spi_end = 1'b0;
  logic [3:0]  spi_count = 4'd0;
  logic        refresh_en = 1'b0;
  logic        ws_busy;
  logic        ws_start;
  logic        wr_bank;
  logic        rd_bank;
  logic [3:0]  ws_count;
  logic        pending;
  logic        drop;
  logic [15:0] frames;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // ws2812 model controls and observations
  bit busy_mode = 1'b1;
  int busy_len = 30;
  int busy_fall = 0;
  int falls = 0;

  // Reference model of the displayed frame
  logic        exp_wr = 1'b0;
  logic [3:0]  exp_count = 4'd0;
  logic [15:0] exp_frames = 16'd0;

  neopix_frame_sched #(
    .NUM_LEDS     (NUM_LEDS),
    .SYSTEM_CLOCK (SYSTEM_CLOCK),
    .LATCH_US     (LATCH_US),
    .REFRESH_HZ   (REFRESH_HZ)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .spi_begin_i  (spi_begin),
    .spi_end_i    (spi_end),
    .spi_count_i  (spi_count),
    .refresh_en_i (refresh_en),
    .ws_busy_i    (ws_busy),
    .ws_start_o   (ws_start),
    .wr_bank_o    (wr_bank),
    .rd_bank_o    (rd_bank),
    .ws_count_o   (ws_count),
    .pending_o    (pending),
    .drop_o       (drop),
    .frames_o     (frames)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ws2812 behaviour: busy from the cycle after it samples start, for busy_len cycles.
  initial begin
    ws_busy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (ws_start && busy_mode) begin
        @(posedge clk);
        #2;
        ws_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #2;
        ws_busy = 1'b0;
        busy_fall = cyc;
        falls++;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [3:0] c);
    spi_count = c;
    spi_end = 1'b1;
    @(posedge clk);
    #1;
    spi_end = 1'b0;
  endtask

  task automatic model_swap(input logic [3:0] c);
    exp_wr = ~exp_wr;
    exp_count = (c > 4'd8) ? 4'd8 : c;
    exp_frames = exp_frames + 16'd1;
  endtask

  task automatic wait_start(input int budget, input string name, output int at);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ws_start && n < budget);
    at = cyc;
    checks++;
    if (ws_start !== 1'b1) begin
      errors++;
      $display("FAIL %s_start_timeout: no ws_start within %0d cycles, required a start", name, budget);
    end
  endtask

  task automatic wait_fall(input int budget);
    int f0;
    int n;
    f0 = falls;
    n = 0;
    while (falls == f0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (falls == f0) begin
      errors++;
      $display("FAIL busy_fall_timeout: busy never fell within %0d cycles, required a fall", budget);
    end
  endtask

  task automatic settle();
    wait_fall(300);
    wait_cycles(LATCH_CYCLES + 4);
  endtask

  task automatic check_display(input string name);
    checks++;
    if ({wr_bank, rd_bank, ws_count, frames} !== {exp_wr, ~exp_wr, exp_count, exp_frames}) begin
      errors++;
      $display("FAIL %s: wr=%b rd=%b count=%0d frames=%0d, required wr=%b rd=%b count=%0d frames=%0d",
               name, wr_bank, rd_bank, ws_count, frames, exp_wr, ~exp_wr, exp_count, exp_frames);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cycles(3);
    checks++;
    if ({ws_start, wr_bank, rd_bank, ws_count, pending, drop, frames} !==
        {1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset_values: got start=%b wr=%b rd=%b count=%0d pend=%b drop=%b frames=%0d, required 0 0 1 0 0 0 0",
               ws_start, wr_bank, rd_bank, ws_count, pending, drop, frames);
    end
    reset = 1'b0;
    wait_cycles(2);
    checks++;
    if ({ws_start, pending, frames} !== {1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL post_reset_idle: got start=%b pend=%b frames=%0d, required 0 0 0", ws_start, pending, frames);
    end
  endtask

  task automatic test_first_frame();
    int t;
    busy_len = 100;
    commit(4'd5);
    checks++;
    if (pending !== 1'b1) begin
      errors++;
      $display("FAIL first_pending: got %b, required 1", pending);
    end
    wait_cycles(1);
    model_swap(4'd5);
    checks++;
    if ({ws_start, pending} !== 2'b10) begin
      errors++;
      $display("FAIL first_start_timing: got start=%b pend=%b, required start=1 pend=0", ws_start, pending);
    end
    check_display("first_frame");
    wait_cycles(3);
    commit(4'd12);
    wait_start(300, "clamp", t);
    checks++;
    if (t !== busy_fall + LATCH_CYCLES + 2) begin
      errors++;
      $display("FAIL latch_spacing: start at %0d, required %0d", t, busy_fall + LATCH_CYCLES + 2);
    end
    model_swap(4'd12);
    check_display("clamp_to_num_leds");
    settle();
  endtask

  task automatic test_back_to_back();
    int t;
    int te;
    logic [3:0] c;
    busy_len = 10;
    c = 4'($urandom_range(0, 15));
    commit(c);
    te = cyc;
    wait_start(10, "b2b_first", t);
    checks++;
    if (t !== te + 1) begin
      errors++;
      $display("FAIL b2b_first_latency: start at %0d, required %0d", t, te + 1);
    end
    model_swap(c);
    check_display("b2b_first");
    for (int i = 0; i < 8; i++) begin
      busy_len = $urandom_range(5, 40);
      wait_cycles($urandom_range(1, 4));
      c = (i == 3) ? 4'd0 : 4'($urandom_range(0, 15));
      commit(c);
      wait_start(200, "b2b", t);
      checks++;
      if (t !== busy_fall + LATCH_CYCLES + 2) begin
        errors++;
        $display("FAIL b2b_spacing[%0d]: start at %0d, required %0d", i, t, busy_fall + LATCH_CYCLES + 2);
      end
      model_swap(c);
      check_display("b2b_frame");
    end
    settle();
  endtask

  task automatic test_overrun();
    int t;
    int starts;
    int drops;
    busy_len = 30;
    commit(4'd6);
    wait_start(10, "overrun", t);
    model_swap(4'd6);
    check_display("overrun_first");
    wait_cycles(2);
    commit(4'd3);
    wait_fall(100);
    wait_cycles(5);
    spi_begin = 1'b1;
    wait_cycles(1);
    spi_begin = 1'b0;
    checks++;
    if ({drop, pending} !== 2'b10) begin
      errors++;
      $display("FAIL overrun_drop: got drop=%b pend=%b, required drop=1 pend=0", drop, pending);
    end
    starts = 0;
    drops = 0;
    for (int i = 0; i < LATCH_CYCLES + 10; i++) begin
      wait_cycles(1);
      if (ws_start) starts++;
      if (drop) drops++;
    end
    checks++;
    if (starts != 0 || drops != 0) begin
      errors++;
      $display("FAIL overrun_quiet: got starts=%0d extra_drops=%0d, required 0 0", starts, drops);
    end
    check_display("overrun_unchanged");
  endtask

  task automatic test_swap_wins();
    busy_len = 8;
    commit(4'd2);
    spi_begin = 1'b1;
    wait_cycles(1);
    spi_begin = 1'b0;
    model_swap(4'd2);
    checks++;
    if ({ws_start, drop, pending} !== 3'b100) begin
      errors++;
      $display("FAIL swap_wins: got start=%b drop=%b pend=%b, required 1 0 0", ws_start, drop, pending);
    end
    check_display("swap_wins");
    settle();
  endtask

  task automatic test_lost_start();
    int s;
    int t;
    busy_mode = 1'b0;
    commit(4'd4);
    wait_start(10, "lost", s);
    model_swap(4'd4);
    commit(4'd1);
    wait_start(30, "after_lost", t);
    checks++;
    if (t !== s + 10) begin
      errors++;
      $display("FAIL lost_start_timeout: restart at %0d, required %0d", t, s + 10);
    end
    model_swap(4'd1);
    check_display("after_lost");
    wait_cycles(12);
    busy_mode = 1'b1;
  endtask

  task automatic test_refresh();
    int s1;
    int s2;
    busy_len = 30;
    refresh_en = 1'b1;
    wait_start(REFRESH_CYCLES + 20, "refresh0", s1);
    for (int i = 0; i < 2; i++) begin
      wait_start(REFRESH_CYCLES + 20, "refresh", s2);
      // One IDLE decision cycle plus the START cycle on top of the timer period.
      checks++;
      if (s2 - s1 !== REFRESH_CYCLES + 2) begin
        errors++;
        $display("FAIL refresh_period: got %0d cycles, required %0d", s2 - s1, REFRESH_CYCLES + 2);
      end
      check_display("refresh_no_swap");
      s1 = s2;
    end
    refresh_en = 1'b0;
    settle();
  endtask

  task automatic test_reset_in_gap();
    int t;
    int starts;
    busy_len = 20;
    commit(4'd7);
    wait_start(10, "rst_gap", t);
    model_swap(4'd7);
    wait_cycles(2);
    commit(4'd1);
    wait_fall(100);
    wait_cycles(5);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    exp_wr = 1'b0;
    exp_count = 4'd0;
    exp_frames = 16'd0;
    checks++;
    if ({ws_start, wr_bank, rd_bank, ws_count, pending, drop, frames} !==
        {1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset_in_gap: got start=%b wr=%b rd=%b count=%0d pend=%b drop=%b frames=%0d, required 0 0 1 0 0 0 0",
               ws_start, wr_bank, rd_bank, ws_count, pending, drop, frames);
    end
    starts = 0;
    for (int i = 0; i < 60; i++) begin
      wait_cycles(1);
      if (ws_start) starts++;
    end
    checks++;
    if (starts != 0) begin
      errors++;
      $display("FAIL reset_in_gap_no_start: got %0d starts, required 0", starts);
    end
    check_display("reset_in_gap_idle");
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_overrun();
    test_swap_wins();
    test_lost_start();
    test_refresh();
    test_reset_in_gap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
